// File: rtl/chan_pkt_framer_if.sv
// Bundle of the framer's control, FIFO-side and uplink-side signals.
//   start/ch/flush : packet request, sampled by the framer in IDLE
//   rdusedw        : FIFO fill level
//   fifo_out       : FIFO read data
//   rdreq          : FIFO read request from the framer
//   data_valid     : qualifies up_data
//   up_data        : framed packet word
//   over           : one-cycle completion pulse
//   status         : result code of the last request
// master : the requester/FIFO side; slave : the framer.
interface chan_pkt_framer_if #(
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned CH_W    = 5,
    parameter int unsigned USEDW_W = 12
);
    logic                start;
    logic [CH_W-1:0]     ch;
    logic                flush;
    logic [USEDW_W-1:0]  rdusedw;
    logic [DATA_W-1:0]   fifo_out;
    logic                rdreq;
    logic                data_valid;
    logic [DATA_W-1:0]   up_data;
    logic                over;
    logic [1:0]          status;

    modport master (
        output start, ch, flush, rdusedw, fifo_out,
        input  rdreq, data_valid, up_data, over, status
    );

    modport slave (
        input  start, ch, flush, rdusedw, fifo_out,
        output rdreq, data_valid, up_data, over, status
    );
endinterface

// File: rtl/chan_pkt_framer.sv
// Per-channel packet framer between a channel's data FIFO and the uplink mux.
// On start it checks the FIFO fill level against the packet length, then
// either emits {header, sequence count, payload, XOR checksum} or reports a
// skip reason on status.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : chan_pkt_framer_if.slave (request, FIFO and uplink signals)
module chan_pkt_framer #(
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned LEN     = 128,
    parameter logic [31:0] HEAD    = 32'hadf90c00,
    parameter int unsigned NCH     = 30,
    parameter int unsigned CH_W    = 5,
    parameter int unsigned USEDW_W = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    chan_pkt_framer_if.slave   bus
);

    localparam int unsigned N_W   = 16;
    localparam int unsigned IDX_W = 17;
    localparam int unsigned CNT_W = 32;

    localparam logic [1:0] ST_FULL  = 2'd0;
    localparam logic [1:0] ST_SHORT = 2'd1;
    localparam logic [1:0] ST_UNDER = 2'd2;
    localparam logic [1:0] ST_BADCH = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        SEND  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic                flush_q, flush_d;
    logic [N_W-1:0]      n_q, n_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DATA_W-1:0]   csum_q, csum_d;
    logic                rdreq_q, rdreq_d;
    logic                dv_q, dv_d;
    logic [DATA_W-1:0]   up_q, up_d;
    logic                over_q, over_d;
    logic [1:0]          status_q, status_d;
    logic                cnt_inc_c;
    logic [CNT_W-1:0]    cnt_q [NCH];
    logic [IDX_W-1:0]    n_ext_c;

    assign n_ext_c = IDX_W'(n_q);

    // State register and registered datapath/outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ch_q     <= '0;
            flush_q  <= 1'b0;
            n_q      <= '0;
            idx_q    <= '0;
            csum_q   <= '0;
            rdreq_q  <= 1'b0;
            dv_q     <= 1'b0;
            up_q     <= '0;
            over_q   <= 1'b0;
            status_q <= '0;
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            flush_q  <= flush_d;
            n_q      <= n_d;
            idx_q    <= idx_d;
            csum_q   <= csum_d;
            rdreq_q  <= rdreq_d;
            dv_q     <= dv_d;
            up_q     <= up_d;
            over_q   <= over_d;
            status_q <= status_d;
        end
    end

    // Per-channel sequence counters, bumped on the header cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NCH); i++) begin
                cnt_q[i] <= '0;
            end
        end else if (cnt_inc_c) begin
            cnt_q[ch_q] <= cnt_q[ch_q] + CNT_W'(1);
        end
    end

    // Next-state and next-output logic. idx_q counts words within SEND:
    // 0 header, 1 count, 2..n+1 payload, n+2 checksum. rdreq is issued for
    // idx 1..n so each FIFO word is on fifo_out while idx is 2..n+1.
    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        flush_d   = flush_q;
        n_d       = n_q;
        idx_d     = idx_q;
        csum_d    = csum_q;
        rdreq_d   = 1'b0;
        dv_d      = 1'b0;
        up_d      = '0;
        over_d    = 1'b0;
        status_d  = status_q;
        cnt_inc_c = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    ch_d    = bus.ch;
                    flush_d = bus.flush;
                    state_d = CHECK;
                end
            end

            CHECK: begin
                idx_d  = '0;
                csum_d = '0;
                if (32'(ch_q) >= NCH) begin
                    status_d = ST_BADCH;
                    state_d  = DONE;
                end else if (32'(bus.rdusedw) >= LEN) begin
                    n_d      = N_W'(LEN);
                    status_d = ST_FULL;
                    state_d  = SEND;
                end else if (flush_q && (bus.rdusedw != '0)) begin
                    // rdusedw < LEN here, so it always fits the length field
                    n_d      = N_W'(bus.rdusedw);
                    status_d = ST_SHORT;
                    state_d  = SEND;
                end else begin
                    status_d = ST_UNDER;
                    state_d  = DONE;
                end
            end

            SEND: begin
                dv_d    = 1'b1;
                idx_d   = idx_q + IDX_W'(1);
                rdreq_d = (idx_q >= IDX_W'(1)) && (idx_q <= n_ext_c);
                if (idx_q == IDX_W'(0)) begin
                    up_d      = DATA_W'({HEAD, N_W'(ch_q), n_q});
                    cnt_inc_c = 1'b1;
                end else if (idx_q == IDX_W'(1)) begin
                    // counter already holds this packet's increment
                    up_d = DATA_W'(cnt_q[ch_q]);
                end else if (idx_q <= n_ext_c + IDX_W'(1)) begin
                    up_d   = bus.fifo_out;
                    csum_d = csum_q ^ bus.fifo_out;
                end else begin
                    up_d    = csum_q;
                    state_d = DONE;
                end
            end

            DONE: begin
                over_d  = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.rdreq      = rdreq_q;
    assign bus.data_valid = dv_q;
    assign bus.up_data    = up_q;
    assign bus.over       = over_q;
    assign bus.status     = status_q;

endmodule
